// File: rtl/decoder_round_controller_pkg.sv
// Shared widths and FSM state encoding for the Helios decoder round controller.
package decoder_round_controller_pkg;

    localparam int CORDINATE_WIDTH   = 3;
    localparam int MATCH_VALUE_WIDTH = 2 * CORDINATE_WIDTH;

    localparam int STATE_W = 4;
    localparam logic [STATE_W-1:0] IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] LOAD    = 4'd1;
    localparam logic [STATE_W-1:0] SETTLE  = 4'd2;
    localparam logic [STATE_W-1:0] START   = 4'd3;
    localparam logic [STATE_W-1:0] OFFER   = 4'd4;
    localparam logic [STATE_W-1:0] STOP    = 4'd5;
    localparam logic [STATE_W-1:0] CAPTURE = 4'd6;
    localparam logic [STATE_W-1:0] SCAN    = 4'd7;
    localparam logic [STATE_W-1:0] DONE    = 4'd8;

endpackage

// File: rtl/decoder_round_controller_defect_scan_unit.sv
// Captures the decoder's defect mask and match buffer, then streams one
// valid/ready record per defect stabilizer in index order.
module defect_scan_unit #(
    parameter int GRID_ROWS       = 4,
    parameter int GRID_COLS       = 5,
    parameter int CORDINATE_WIDTH = 3,
    localparam int N  = GRID_ROWS * GRID_COLS,
    localparam int MW = 2 * CORDINATE_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       capture,
    input  logic                       scan_en,
    input  logic [N-1:0]               measurement_in,
    input  logic [N*MW-1:0]            match_value_in,
    input  logic                       result_ready,
    output logic                       result_valid,
    output logic [CORDINATE_WIDTH-1:0] result_y,
    output logic [CORDINATE_WIDTH-1:0] result_x,
    output logic [MW-1:0]              result_match,
    output logic                       result_last,
    output logic                       scan_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]               mask;
    logic [N*MW-1:0]            match_buf;
    logic [IW-1:0]              idx;
    logic [CORDINATE_WIDTH-1:0] row;
    logic [CORDINATE_WIDTH-1:0] col;
    logic [N-1:0]               above;
    logic                       hit;
    logic                       advance;

    // Clear defect indices fall through in a single cycle; set ones wait for the handshake.
    assign hit       = scan_en && mask[idx];
    assign advance   = scan_en && (!mask[idx] || result_ready);
    assign scan_done = advance && (idx == IW'(N - 1));

    always_comb begin
        above = '0;
        for (int i = 0; i < N; i++)
            above[i] = mask[i] && (i > int'(idx));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask      <= '0;
            match_buf <= '0;
            idx       <= '0;
            row       <= '0;
            col       <= '0;
        end else if (capture) begin
            mask      <= measurement_in;
            match_buf <= match_value_in;
            idx       <= '0;
            row       <= '0;
            col       <= '0;
        end else if (advance && !scan_done) begin
            idx <= idx + 1'b1;
            if (col == CORDINATE_WIDTH'(GRID_COLS - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign result_valid = hit;
    assign result_y     = row;
    assign result_x     = col;
    assign result_match = match_buf[int'(idx)*MW +: MW];
    assign result_last  = hit && (above == '0);

endmodule

// File: rtl/decoder_round_controller.sv
// Round sequencer: frame accept, measurement load, settle, offer window with
// budget/early exit, stop, capture, and per-defect result streaming.
module decoder_round_controller #(
    parameter int GRID_ROWS        = 4,
    parameter int GRID_COLS        = 5,
    parameter int CORDINATE_WIDTH  = decoder_round_controller_pkg::CORDINATE_WIDTH,
    parameter int SETTLE_CYCLES    = 100,
    parameter int OFFER_CYCLES     = 2500,
    parameter int MIN_OFFER_CYCLES = 16,
    parameter int TIMER_WIDTH      = 16,
    localparam int N  = GRID_ROWS * GRID_COLS,
    localparam int MW = 2 * CORDINATE_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N-1:0]               syndrome_in,
    input  logic                       syndrome_valid,
    output logic                       syndrome_ready,
    output logic [N-1:0]               measurement_value_out,
    output logic                       measurement_valid_out,
    output logic                       start_offer,
    output logic                       stop_offer,
    input  logic                       early_done,
    input  logic [N-1:0]               measurement_in,
    input  logic [N*MW-1:0]            match_value_in,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [CORDINATE_WIDTH-1:0] result_y,
    output logic [CORDINATE_WIDTH-1:0] result_x,
    output logic [MW-1:0]              result_match,
    output logic                       result_last,
    output logic                       round_done,
    output logic [TIMER_WIDTH-1:0]     offer_cycles_used,
    output logic                       busy
);

    import decoder_round_controller_pkg::*;

    // Zero-length windows degrade to a single cycle.
    localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST =
        TIMER_WIDTH'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TIMER_WIDTH-1:0] OFFER_LAST =
        TIMER_WIDTH'((OFFER_CYCLES > 1) ? OFFER_CYCLES - 1 : 0);
    localparam logic [TIMER_WIDTH-1:0] MIN_LAST =
        TIMER_WIDTH'((MIN_OFFER_CYCLES > 1) ? MIN_OFFER_CYCLES - 1 : 0);

    logic [STATE_W-1:0]     state;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   offer_exit;
    logic                   scan_done;

    assign offer_exit = (state == OFFER) &&
                        ((timer == OFFER_LAST) || (early_done && (timer >= MIN_LAST)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            timer                 <= '0;
            measurement_value_out <= '0;
            offer_cycles_used     <= '0;
        end else begin
            case (state)
                IDLE: if (syndrome_valid) begin
                    measurement_value_out <= syndrome_in;
                    state                 <= LOAD;
                end
                LOAD: begin
                    timer <= '0;
                    state <= SETTLE;
                end
                SETTLE: if (timer == SETTLE_LAST) state <= START;
                        else                      timer <= timer + 1'b1;
                START: begin
                    timer <= '0;
                    state <= OFFER;
                end
                OFFER: if (offer_exit) begin
                    offer_cycles_used <= timer + 1'b1;
                    state             <= STOP;
                end else begin
                    timer <= timer + 1'b1;
                end
                STOP:    state <= CAPTURE;
                CAPTURE: state <= SCAN;
                SCAN:    if (scan_done) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pulses decode straight from the state register, so reset silences them at once.
    assign syndrome_ready        = (state == IDLE);
    assign measurement_valid_out = (state == LOAD);
    assign start_offer           = (state == START);
    assign stop_offer            = (state == STOP);
    assign round_done            = (state == DONE);
    assign busy                  = (state != IDLE);

    defect_scan_unit #(
        .GRID_ROWS       (GRID_ROWS),
        .GRID_COLS       (GRID_COLS),
        .CORDINATE_WIDTH (CORDINATE_WIDTH)
    ) u_scan (
        .clk            (clk),
        .reset          (reset),
        .capture        (state == CAPTURE),
        .scan_en        (state == SCAN),
        .measurement_in (measurement_in),
        .match_value_in (match_value_in),
        .result_ready   (result_ready),
        .result_valid   (result_valid),
        .result_y       (result_y),
        .result_x       (result_x),
        .result_match   (result_match),
        .result_last    (result_last),
        .scan_done      (scan_done)
    );

endmodule

// File: tb/tb_decoder_round_controller.sv
// Scoreboard bench for decoder_round_controller with a stub decoder that echoes
// the loaded frame as its defect mask and returns a programmable match table.
module tb_decoder_round_controller;

    localparam int R = 4, C = 5, CW = 3, N = R * C, MW = 2 * CW, TW = 16;
    localparam int SETTLE = 100, OFFER = 2500, MINO = 16;
    localparam int LIM = 20000;
    localparam logic [N-1:0] F1 = 20'h0B003;   // (0,0) (0,1) (2,2) (2,3) (3,0)
    localparam logic [N-1:0] FB = 20'h80080;   // (1,2) (3,4)

    logic           clk = 1'b0, reset = 1'b0;
    logic [N-1:0]   syndrome_in = '0;
    logic           syndrome_valid = 1'b0, syndrome_ready;
    logic [N-1:0]   measurement_value_out;
    logic           measurement_valid_out, start_offer, stop_offer;
    logic           early_done = 1'b0;
    logic [N-1:0]   measurement_in = '0;
    logic [N*MW-1:0] match_value_in;
    logic           result_valid, result_ready = 1'b1;
    logic [CW-1:0]  result_y, result_x;
    logic [MW-1:0]  result_match;
    logic           result_last, round_done, busy;
    logic [TW-1:0]  offer_cycles_used;

    logic [MW-1:0]  match_tab [N];
    logic [12:0]    exp_q [$];
    logic [12:0]    held_rec;
    logic [N-1:0]   exp_frame = '0;
    int n_chk = 0, n_err = 0;
    int cyc = 0, acc = 0, starts = 0, stops = 0, dones = 0, hs = 0, rv_cycles = 0;
    int rdy_viol = 0, gap = 0, last_gap = 0, lat = 0;
    int acc_cyc = 0, done_cyc = -10, done_before_acc = 0, exp_offer = OFFER;
    bit in_offer = 0, held = 0, lat_on = 0, chk_lat = 1, rand_rdy = 0;

    decoder_round_controller #(
        .GRID_ROWS(R), .GRID_COLS(C), .CORDINATE_WIDTH(CW), .SETTLE_CYCLES(SETTLE),
        .OFFER_CYCLES(OFFER), .MIN_OFFER_CYCLES(MINO), .TIMER_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset), .syndrome_in(syndrome_in), .syndrome_valid(syndrome_valid),
        .syndrome_ready(syndrome_ready), .measurement_value_out(measurement_value_out),
        .measurement_valid_out(measurement_valid_out), .start_offer(start_offer),
        .stop_offer(stop_offer), .early_done(early_done), .measurement_in(measurement_in),
        .match_value_in(match_value_in), .result_valid(result_valid), .result_ready(result_ready),
        .result_y(result_y), .result_x(result_x), .result_match(result_match),
        .result_last(result_last), .round_done(round_done),
        .offer_cycles_used(offer_cycles_used), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        match_value_in = '0;
        for (int i = 0; i < N; i++) match_value_in[i*MW +: MW] = match_tab[i];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void push_exp(input logic [N-1:0] f);
        int lasti = -1;
        for (int i = 0; i < N; i++) if (f[i]) lasti = i;
        for (int i = 0; i < N; i++)
            if (f[i]) exp_q.push_back({CW'(i / C), CW'(i % C), match_tab[i], (i == lasti)});
    endfunction

    initial forever begin
        @(posedge clk); #1;
        result_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor, stub decoder and scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        logic [12:0] rec, e;
        cyc++;
        rec = {result_y, result_x, result_match, result_last};
        if (!reset) begin
            in_offer = 0; held = 0; lat_on = 0;
        end else begin
            if (lat_on) lat++;
            if (syndrome_ready == busy) rdy_viol++;
            if (measurement_valid_out) begin
                measurement_in = measurement_value_out;
                chk("load_frame", 32'(measurement_value_out), 32'(exp_frame));
            end
            if (start_offer) begin starts++; in_offer = 1; gap = 0; end
            else if (stop_offer) begin stops++; in_offer = 0; last_gap = gap; end
            else if (in_offer) gap++;
            if (held) chk("stall_hold", {result_valid, rec}, {1'b1, held_rec});
            held = result_valid && !result_ready;
            held_rec = rec;
            if (result_valid) rv_cycles++;
            if (result_valid && result_ready) begin
                hs++;
                chk("rec_avail", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("record", 32'(rec), 32'(e));
                end
            end
            if (round_done) begin
                dones++; done_cyc = cyc;
                if (lat_on && chk_lat) chk("latency", lat, 1+1+SETTLE+1+exp_offer+1+1+N+1);
                lat_on = 0;
            end
            if (syndrome_valid && syndrome_ready) begin
                acc++; acc_cyc = cyc; done_before_acc = done_cyc;
                exp_frame = syndrome_in;
                push_exp(syndrome_in);
                lat = 1; lat_on = 1;
            end
        end
    end

    task automatic wait_acc(input int target);
        for (int k = 0; k < LIM && acc < target; k++) begin @(negedge clk); #1; end
        chk("accept_timeout", 32'(acc >= target), 1);
    endtask

    task automatic wait_dones(input int target);
        for (int k = 0; k < LIM && dones < target; k++) begin @(negedge clk); #1; end
        chk("round_timeout", 32'(dones >= target), 1);
    endtask

    task automatic send_frame(input logic [N-1:0] f);
        int a0 = acc;
        @(posedge clk); #1;
        syndrome_in = f; syndrome_valid = 1'b1;
        wait_acc(a0 + 1);
        @(posedge clk); #1;
        syndrome_valid = 1'b0;
    endtask

    task automatic run_round(input logic [N-1:0] f, input string tag);
        int d0 = dones, s0 = starts, p0 = stops, h0 = hs, r0 = rv_cycles;
        send_frame(f);
        wait_dones(d0 + 1);
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_dones"}, dones - d0, 1);
        chk({tag, "_starts"}, starts - s0, 1);
        chk({tag, "_stops"}, stops - p0, 1);
        chk({tag, "_records"}, hs - h0, $countones(f));
        if (!rand_rdy) chk({tag, "_valid_cycles"}, rv_cycles - r0, $countones(f));
        chk({tag, "_offer_gap"}, last_gap, exp_offer);
        chk({tag, "_offer_used"}, 32'(offer_cycles_used), exp_offer);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {syndrome_ready, busy, measurement_valid_out, start_offer,
                             stop_offer, round_done, result_valid, result_last}, 8'h80);
        chk({tag, "_data"}, {result_y, result_x, result_match}, 0);
        chk({tag, "_offer_used"}, 32'(offer_cycles_used), 0);
        chk({tag, "_meas"}, 32'(measurement_value_out), 0);
    endtask

    initial begin
        int d0, a0, s0, p0;
        for (int i = 0; i < N; i++) match_tab[i] = MW'(7 * i + 5);
        match_tab[0]  = {3'd0, 3'd1};
        match_tab[1]  = {3'd0, 3'd0};
        match_tab[12] = {3'd2, 3'd3};
        match_tab[13] = {3'd2, 3'd2};
        match_tab[15] = {3'd3, 3'd5};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b1;

        early_done = 1'b0; exp_offer = OFFER;
        run_round(F1, "budget");

        early_done = 1'b1; exp_offer = MINO;
        run_round(F1, "early");
        run_round('0, "empty");

        chk_lat = 0; rand_rdy = 1;
        run_round(F1, "backpressure");
        rand_rdy = 0; chk_lat = 1;

        // Back-to-back frames with syndrome_valid held high.
        d0 = dones; a0 = acc;
        @(posedge clk); #1;
        syndrome_in = F1; syndrome_valid = 1'b1;
        wait_acc(a0 + 1);
        @(posedge clk); #1;
        syndrome_in = FB;
        wait_acc(a0 + 2);
        chk("b2b_accept_after_done", acc_cyc - done_before_acc, 1);
        @(posedge clk); #1;
        syndrome_valid = 1'b0;
        wait_dones(d0 + 2);
        repeat (2) @(negedge clk);
        chk("b2b_queue_left", exp_q.size(), 0);

        // Reset during OFFER abandons the round.
        early_done = 1'b0; exp_offer = OFFER;
        s0 = starts; p0 = stops; d0 = dones;
        send_frame(F1);
        for (int k = 0; k < LIM && starts == s0; k++) begin @(negedge clk); #1; end
        chk("mid_start_seen", starts - s0, 1);
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_rst");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("mid_no_stop", stops - p0, 0);
        chk("mid_no_done", dones - d0, 0);
        chk("mid_idle", {syndrome_ready, busy}, 2'b10);

        early_done = 1'b1; exp_offer = MINO;
        run_round(F1, "post_rst");

        chk("ready_vs_busy", rdy_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
